// File: rtl/avalon_arb_pkg.sv
// Shared types and helpers for the Avalon-MM register-port arbiter.
package avalon_arb_pkg;

  localparam int unsigned MAX_MASTERS = 8;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned TAG_IDW = idx_w(MAX_MASTERS);

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
module rr_select #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int unsigned   idx;
  logic [IW-1:0] sel;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      sel = IW'(idx);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/avalon_arbiter.sv
// Round-robin arbiter sharing one avalon_adapter register port between masters,
// with registered command stage, read-return tagging and optional grant lock.
module avalon_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int MASTERS      = 2,
  parameter int ADDRESSWIDTH = 4,
  parameter int IDW          = idx_w(MASTERS)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [MASTERS-1:0]                        m_read,
  input  logic [MASTERS-1:0]                        m_write,
  input  logic [MASTERS-1:0]                        m_lock,
  input  logic [MASTERS-1:0][ADDRESSWIDTH-1:0]      m_address,
  input  logic [MASTERS-1:0][31:0]                  m_data_in,
  output logic [MASTERS-1:0]                        m_waitrequest,
  output logic [MASTERS-1:0]                        m_read_valid,
  output logic [31:0]                               m_data_out,
  output logic                                      s_read,
  output logic                                      s_write,
  output logic [ADDRESSWIDTH-1:0]                   s_address,
  output logic [31:0]                               s_data_in,
  input  logic                                      s_read_valid,
  input  logic [31:0]                               s_data_out
);

  logic [MASTERS-1:0]      req, sel_gnt, grant;
  logic [IDW-1:0]          sel_idx, gnt_idx;
  logic                    accept, acc_write;

  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                    locked_q, locked_d;
  logic [IDW-1:0]          lock_id_q, lock_id_d;
  logic                    s_read_q, s_read_d;
  logic                    s_write_q, s_write_d;
  logic [ADDRESSWIDTH-1:0] s_address_q, s_address_d;
  logic [31:0]             s_data_in_q, s_data_in_d;
  rd_tag_t [1:0]           pipe_q, pipe_d;
  logic [MASTERS-1:0]      m_read_valid_q, m_read_valid_d;
  logic [31:0]             m_data_out_q, m_data_out_d;

  rr_select #(
    .N  (MASTERS),
    .IW (IDW)
  ) u_rr_select (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt     (sel_gnt),
    .gnt_idx (sel_idx)
  );

  always_comb begin
    req     = m_read | m_write;
    grant   = '0;
    gnt_idx = '0;
    if (!reset) begin
      if (locked_q) begin
        if (req[lock_id_q]) begin
          grant[lock_id_q] = 1'b1;
          gnt_idx          = lock_id_q;
        end
      end else begin
        grant   = sel_gnt;
        gnt_idx = sel_idx;
      end
    end
    accept    = |grant;
    acc_write = m_write[gnt_idx];
  end

  assign m_waitrequest = ~grant;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    locked_d    = locked_q;
    lock_id_d   = lock_id_q;
    s_address_d = s_address_q;
    s_data_in_d = s_data_in_q;

    // A cycle with m_lock[lock_id] low still arbitrates as locked; only the
    // next cycle is open. A fresh lock taken in the same cycle overrides.
    if (locked_q && !m_lock[lock_id_q]) begin
      locked_d = 1'b0;
    end
    if (accept) begin
      rr_ptr_d    = (gnt_idx == IDW'(MASTERS - 1)) ? '0 : gnt_idx + IDW'(1);
      s_address_d = m_address[gnt_idx];
      s_data_in_d = m_data_in[gnt_idx];
      if (m_lock[gnt_idx]) begin
        locked_d  = 1'b1;
        lock_id_d = gnt_idx;
      end
    end

    s_read_d  = accept & ~acc_write;
    s_write_d = accept & acc_write;

    pipe_d[0].valid = accept & ~acc_write;
    pipe_d[0].id    = TAG_IDW'(gnt_idx);
    pipe_d[1]       = pipe_q[0];

    m_read_valid_d = (s_read_valid && pipe_q[1].valid) ? (MASTERS'(1) << pipe_q[1].id) : '0;
    m_data_out_d   = s_read_valid ? s_data_out : m_data_out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q       <= '0;
      locked_q       <= 1'b0;
      lock_id_q      <= '0;
      s_read_q       <= 1'b0;
      s_write_q      <= 1'b0;
      s_address_q    <= '0;
      s_data_in_q    <= '0;
      pipe_q         <= '0;
      m_read_valid_q <= '0;
      m_data_out_q   <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      locked_q       <= locked_d;
      lock_id_q      <= lock_id_d;
      s_read_q       <= s_read_d;
      s_write_q      <= s_write_d;
      s_address_q    <= s_address_d;
      s_data_in_q    <= s_data_in_d;
      pipe_q         <= pipe_d;
      m_read_valid_q <= m_read_valid_d;
      m_data_out_q   <= m_data_out_d;
    end
  end

  assign s_read       = s_read_q;
  assign s_write      = s_write_q;
  assign s_address    = s_address_q;
  assign s_data_in    = s_data_in_q;
  assign m_read_valid = m_read_valid_q;
  assign m_data_out   = m_data_out_q;

  a_tag_match: assert property (@(posedge clk) disable iff (reset)
    s_read_valid == pipe_q[1].valid);

endmodule
